// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read controller and its skid buffer.
// The burst FSM states are used only when FIFO_RD_BURST_EN is defined.
package fifo_rd_pkg;

    localparam int SKID_DEPTH     = 2;
    localparam int SKID_CNT_W     = $clog2(SKID_DEPTH + 1);
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_CNT_W  = 4;
    localparam int BURST_CNT_W    = 4;

    typedef enum logic {
        IDLE,
        BURST
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer; the oldest entry is always presented on out_data.
module fifo_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [SKID_CNT_W-1:0] count
);

    logic [DATA_W-1:0]     head_q, head_d;
    logic [DATA_W-1:0]     tail_q, tail_d;
    logic [SKID_CNT_W-1:0] count_q, count_d;
    logic                  retire;

    assign out_valid = (count_q != '0);
    assign out_data  = head_q;
    assign count     = count_q;
    assign retire    = out_valid && out_ready;

    // A simultaneous capture and retire keeps occupancy and shifts the queue up by one.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({in_valid, retire})
            2'b10: begin
                if (count_q == '0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
                count_d = count_q + SKID_CNT_W'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - SKID_CNT_W'(1);
            end
            2'b11: begin
                if (count_q == SKID_CNT_W'(1)) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Pops a synchronous FIFO into a 2-entry skid buffer feeding a valid/ready port.
// Define FIFO_RD_BURST_EN to pop only in bursts of BURST_LEN words (IDLE/BURST FSM).
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rd_en0,
    input  logic [DATA_W-1:0] read_data,
    input  logic              empty,
    input  logic [CNT_W-1:0]  data_avail,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       word_cnt
);

    logic [SKID_CNT_W-1:0] skidCount;
    logic [SKID_CNT_W-1:0] creditUsed;
    logic                  inFlight_q;
    logic                  popPermit;
    logic                  xfer;
    logic [15:0]           wordCnt_q, wordCnt_d;

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inFlight_q),
        .in_data   (read_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (skidCount)
    );

    assign xfer = out_valid && out_ready;

    // The slot freed by this cycle's transfer is counted as available, so a steady stream runs at one word per clock.
    assign creditUsed = skidCount - SKID_CNT_W'(xfer) + SKID_CNT_W'(inFlight_q);
    assign rd_en0     = reset && !empty && popPermit && (creditUsed < SKID_CNT_W'(SKID_DEPTH));

    assign wordCnt_d = xfer ? wordCnt_q + 16'd1 : wordCnt_q;
    assign word_cnt  = wordCnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            inFlight_q <= 1'b0;
            wordCnt_q  <= '0;
        end else begin
            inFlight_q <= rd_en0;
            wordCnt_q  <= wordCnt_d;
        end
    end

`ifdef FIFO_RD_BURST_EN
    localparam logic [CNT_W:0] BurstLenAvail = (CNT_W + 1)'(BURST_LEN);

    rd_state_e              state_q;
    logic [BURST_CNT_W-1:0] burstLeft_q;

    assign popPermit = (state_q == BURST);

    // The remaining-word count steps on every pop; the last pop of a burst returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            burstLeft_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ({1'b0, data_avail} >= BurstLenAvail) begin
                        state_q     <= BURST;
                        burstLeft_q <= BURST_CNT_W'(BURST_LEN);
                    end
                end
                BURST: begin
                    if (rd_en0) begin
                        burstLeft_q <= burstLeft_q - BURST_CNT_W'(1);
                        if (burstLeft_q == BURST_CNT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    localparam int unusedBurstCfg = BURST_LEN + BURST_CNT_W;

    logic [CNT_W-1:0] unusedAvail;

    assign unusedAvail = data_avail;
    assign popPermit   = 1'b1;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: behavioural synch_fifo model plus an in-order scoreboard.
// Define FIFO_RD_BURST_EN to also run the burst-mode scenario.
module tb_fifo_rd_ctrl;

    localparam int DATA_W    = 16;
    localparam int CNT_W     = 4;
    localparam int BURST_LEN = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rd_en0;
    logic [DATA_W-1:0] read_data = '0;
    logic              empty = 1'b1;
    logic [CNT_W-1:0]  data_avail = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       word_cnt;

    int checks   = 0;
    int errors   = 0;
    int cycle    = 0;
    int popCount = 0;
    bit popReq   = 1'b0;
    bit sawXfer  = 1'b0;

    logic [DATA_W-1:0] fifoQ[$];
    logic [DATA_W-1:0] expQ[$];

    fifo_rd_ctrl #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en0     (rd_en0),
        .read_data  (read_data),
        .empty      (empty),
        .data_avail (data_avail),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic void updFlags();
        empty      = (fifoQ.size() == 0);
        data_avail = (fifoQ.size() > 15) ? 4'd15 : 4'(fifoQ.size());
    endfunction

    task automatic pushWord(input logic [DATA_W-1:0] w);
        fifoQ.push_back(w);
        expQ.push_back(w);
        updFlags();
    endtask

    // Outputs are sampled at the falling edge; the FIFO model reacts 1ns after the rising edge.
    task automatic step();
        logic [DATA_W-1:0] expd;
        @(negedge clk);
        cycle++;
        sawXfer = 1'b0;
        if (reset && out_valid === 1'b1 && out_ready) begin
            sawXfer = 1'b1;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL extra_word: got %h, required no transfer", out_data);
            end else begin
                expd = expQ.pop_front();
                if (out_data !== expd) begin
                    errors++;
                    $display("[TB] FAIL order: got %h, required %h", out_data, expd);
                end
            end
        end
        popReq = (rd_en0 === 1'b1);
        if (popReq) begin
            checks++;
            if (empty !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pop_on_empty: got rd_en0=1 with empty=%b, required empty=0", empty);
            end
        end
        @(posedge clk);
        #1;
        if (popReq && fifoQ.size() > 0) begin
            read_data = fifoQ.pop_front();
            popCount++;
        end
        updFlags();
    endtask

    task automatic applyReset();
        reset = 1'b0;
        fifoQ.delete();
        expQ.delete();
        updFlags();
        step();
        step();
        reset    = 1'b1;
        popCount = 0;
    endtask

    task automatic drain(input string name, input int maxCyc);
        for (int i = 0; i < maxCyc && expQ.size() != 0; i++) step();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d words undelivered, required 0", name, expQ.size());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        pushWord(16'h5A5A);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, required 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h, required 0000", out_data);
        end
        checks++;
        if (word_cnt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %h, required 0000", word_cnt);
        end
        checks++;
        if (popReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rd_en0: got %b, required 0", popReq);
        end
        reset     = 1'b1;
        out_ready = 1'b1;
        drain("reset_release", 20);
        checks++;
        if (word_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL reset_release_cnt: got %0d, required 1", word_cnt);
        end
    endtask

    task automatic test_two_words();
        int first = -1;
        int second = -1;
        applyReset();
        out_ready = 1'b1;
        pushWord(16'h1234);
        pushWord(16'hABCD);
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            step();
            if (sawXfer) begin
                if (first < 0) first = cycle;
                else second = cycle;
            end
        end
        drain("two_words", 1);
        checks++;
        if (first < 0 || second != first + 1) begin
            errors++;
            $display("[TB] FAIL two_words_gap: got first=%0d second=%0d, required consecutive", first, second);
        end
        checks++;
        if (word_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL two_words_cnt: got %0d, required 2", word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last = -1;
        int nX = 0;
        applyReset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) pushWord(16'h0100 + 16'(i));
        for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
            step();
            if (sawXfer) begin
                if (first < 0) first = cycle;
                last = cycle;
                nX++;
            end
        end
        drain("b2b", 1);
        checks++;
        if (nX != 8 || last - first != 7) begin
            errors++;
            $display("[TB] FAIL b2b_rate: got %0d words over %0d cycles, required 8 over 7", nX, last - first);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] w[8];
        bit stableOk = 1'b1;
        applyReset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = 16'($urandom_range(0, 65535));
            pushWord(w[i]);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 3 && (out_valid !== 1'b1 || out_data !== w[0])) stableOk = 1'b0;
        end
        checks++;
        if (popCount != 2) begin
            errors++;
            $display("[TB] FAIL bp_pops: got %0d, required 2", popCount);
        end
        checks++;
        if (popReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_rd_en0: got %b, required 0", popReq);
        end
        checks++;
        if (!stableOk || out_data !== w[0]) begin
            errors++;
            $display("[TB] FAIL bp_stable: got %h valid=%b, required %h valid=1", out_data, out_valid, w[0]);
        end
        out_ready = 1'b1;
        drain("bp", 40);
        checks++;
        if (word_cnt !== 16'd8 || popCount != 8) begin
            errors++;
            $display("[TB] FAIL bp_total: got cnt=%0d pops=%0d, required 8 and 8", word_cnt, popCount);
        end
    endtask

    task automatic test_toggle();
        applyReset();
        for (int i = 0; i < 8; i++) pushWord(16'($urandom_range(0, 65535)));
        out_ready = 1'b0;
        for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
            out_ready = !out_ready;
            step();
        end
        drain("toggle", 1);
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (word_cnt !== 16'd8 || popCount != 8 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL toggle_total: got cnt=%0d pops=%0d valid=%b, required 8, 8, 0", word_cnt, popCount, out_valid);
        end
    endtask

    task automatic test_reset_midread();
        applyReset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pushWord(16'hD000 + 16'(i));
        step();
        checks++;
        if (popCount != 1) begin
            errors++;
            $display("[TB] FAIL midread_pop: got %0d pops, required 1", popCount);
        end
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midread_reset: got valid=%b cnt=%0d, required 0 and 0", out_valid, word_cnt);
        end
        expQ = fifoQ;
        reset     = 1'b1;
        out_ready = 1'b1;
        drain("midread", 30);
        step();
        checks++;
        if (word_cnt !== 16'd4 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midread_total: got cnt=%0d valid=%b, required 4 and 0", word_cnt, out_valid);
        end
    endtask

    task automatic test_wrap();
        applyReset();
        out_ready = 1'b0;
        dut.wordCnt_q = 16'hFFFF;
        step();
        checks++;
        if (word_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preset: got %h, required ffff", word_cnt);
        end
        for (int i = 0; i < 4; i++) pushWord(16'hE000 + 16'(i));
        out_ready = 1'b1;
        sawXfer = 1'b0;
        for (int i = 0; i < 20 && !sawXfer; i++) step();
        checks++;
        if (!sawXfer || word_cnt !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got %h, required 0000", word_cnt);
        end
        drain("wrap", 20);
        checks++;
        if (word_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL wrap_after: got %0d, required 3", word_cnt);
        end
    endtask

`ifdef FIFO_RD_BURST_EN
    task automatic test_burst();
        applyReset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) pushWord(16'hB000 + 16'(i));
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (popCount != 0) begin
            errors++;
            $display("[TB] FAIL burst_short: got %0d pops, required 0", popCount);
        end
        pushWord(16'hB003);
        drain("burst", 20);
        checks++;
        if (popCount != 4) begin
            errors++;
            $display("[TB] FAIL burst_pops: got %0d, required 4", popCount);
        end
        for (int i = 0; i < 3; i++) pushWord(16'hB100 + 16'(i));
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (popCount != 4) begin
            errors++;
            $display("[TB] FAIL burst_idle: got %0d pops, required 4", popCount);
        end
    endtask
`endif

    initial begin
        $display("[TB] fifo_rd_ctrl bench start");
        test_reset();
        test_two_words();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_reset_midread();
        test_wrap();
`ifdef FIFO_RD_BURST_EN
        test_burst();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the FIFO data_avail count.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning the words per burst (1..8), used only when burst mode is compiled in.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port rd_en0, output, 1 bit: pop strobe to synch_fifo.
REQ-007 SHALL have port read_data, input, DATA_W bits: FIFO read word, valid one clk after rd_en0 is sampled high.
REQ-008 SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have port data_avail, input, CNT_W bits: FIFO occupancy.
REQ-010 SHALL have port out_data, output, DATA_W bits: downstream data.
REQ-011 SHALL have port out_valid, output, 1 bit: downstream valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-013 SHALL have port word_cnt, output, 16 bits: count of completed downstream transfers.

Function
REQ-014 SHALL hold popped words in a 2-entry skid buffer and present its oldest entry on out_data.
REQ-015 SHALL drive out_valid high whenever the skid buffer holds at least 1 word.
REQ-016 SHALL complete a transfer on a cycle with out_valid && out_ready, and SHALL then retire the head entry.
REQ-017 SHALL assert rd_en0 only when empty=0, (skid occupancy + in-flight reads) < 2, and pop is permitted (REQ-028/029).
REQ-018 SHALL capture read_data into the skid buffer the cycle after rd_en0 was high, with no word lost or duplicated.
REQ-019 SHALL sustain 1 word/clk when out_ready is held high and the FIFO is non-empty (steady state).
REQ-020 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL handle a capture and a retire in the same cycle by keeping occupancy unchanged and advancing order.
REQ-022 SHALL preserve FIFO order end to end.
REQ-023 SHALL increment word_cnt by 1 per transfer, wrapping from 16'hFFFF to 0.
REQ-024 SHALL keep rd_en0 low when empty=1, regardless of credit.

Reset
REQ-025 SHALL, when reset=0 at a clk edge, set skid occupancy to 0, in-flight to 0, out_valid=0, out_data=0, word_cnt=0, and FSM=IDLE.
REQ-026 SHALL hold rd_en0=0 during reset.
REQ-027 SHALL, on reset mid-burst or mid-read, discard the in-flight word with no capture after reset deasserts.

Configuration
REQ-028 SHALL compile in burst mode under macro FIFO_RD_BURST_EN, using FSM states IDLE and BURST.
- IDLE: move to BURST when data_avail >= BURST_LEN; no pops in IDLE.
- BURST: pop exactly BURST_LEN words, stalling on credit, then return to IDLE.
- Remaining burst count decrements on each rd_en0.
REQ-029 SHALL, without FIFO_RD_BURST_EN, have no FSM and permit a pop on every cycle that REQ-017 allows.

Structure
REQ-030 SHALL place the skid depth constant (2), default DATA_W/CNT_W, and the state enum {IDLE, BURST} in package fifo_rd_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module fifo_skid_buf (ports clk, reset, in_valid, in_data, out_valid, out_ready, out_data, count).

Verification
REQ-032 SHALL verify: write 16'h1234, 16'hABCD to synch_fifo, out_ready=1 -> out_data 1234 then ABCD on consecutive cycles, word_cnt=2.
REQ-033 SHALL verify: fill FIFO with 8 words, out_ready=0 -> exactly 2 pops, rd_en0 low, out_data stable at word 1; then out_ready=1 -> 8 words delivered in order.
REQ-034 SHALL verify: out_ready toggles 1010... over 8 words -> no loss or duplicate, and empty=1 is never popped.
REQ-035 SHALL verify: reset=0 one cycle after rd_en0 -> out_valid=0 and word_cnt=0 next cycle, with no stale word after release.
REQ-036 SHALL verify, with FIFO_RD_BURST_EN and BURST_LEN=4: 3 words give no rd_en0; the 4th word gives 4 pops, then IDLE.
REQ-037 SHALL verify: word_cnt preset path at 16'hFFFF plus 1 transfer -> 0.
